// File: rtl/cu_issue_pkg.sv
// Shared types for the compute-unit issue path: decoded uop layout,
// register-class and execution-unit encodings used by issue and scoreboard.
package cu_issue_pkg;

    localparam int PAYLOAD_W = 64;

    // Register classes; any value with bit 1 set is a vector register.
    localparam logic [1:0] CLS_S = 2'b00;
    localparam logic [1:0] CLS_F = 2'b01;
    localparam logic [1:0] CLS_V = 2'b10;

    localparam logic [1:0] UNIT_ALU = 2'b00;
    localparam logic [1:0] UNIT_LSU = 2'b01;
    localparam logic [1:0] UNIT_FPU = 2'b10;
    localparam logic [1:0] UNIT_VEC = 2'b11;

    typedef struct packed {
        logic                 rs1_v;
        logic                 rs2_v;
        logic                 rd_v;
        logic [1:0]           rs1_cls;
        logic [1:0]           rs2_cls;
        logic [1:0]           rd_cls;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 rs1_fwd;
        logic                 rs2_fwd;
        logic [1:0]           unit;
        logic                 is_ctrl;
        logic [PAYLOAD_W-1:0] payload;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

endpackage

// File: rtl/issue_pair_check.sv
// Combinational issue decision for the two oldest queue slots.
// Ports: slot valids, unit/ctrl of each slot, stalls, exec_ready, flush -> accept0/1.
module issue_pair_check (
    input  logic       issue0_valid,
    input  logic       issue1_valid,
    input  logic [1:0] unit0,
    input  logic [1:0] unit1,
    input  logic       ctrl0,
    input  logic       ctrl1,
    input  logic       stall0,
    input  logic       stall1,
    input  logic       exec_ready,
    input  logic       flush,
    output logic       accept0,
    output logic       accept1
);

    logic pair_ok;

    // Two uops may share a cycle only on different units, and control
    // flow always issues alone so redirects stay precise.
    assign pair_ok = (unit1 != unit0) & ~ctrl0 & ~ctrl1;

    assign accept0 = issue0_valid & ~stall0 & exec_ready & ~flush;

    // Slot 1 rides on slot 0 so issue stays in program order.
    assign accept1 = accept0 & issue1_valid & ~stall1 & pair_ok;

endmodule

// File: rtl/issue_queue.sv
// In-order dual-enqueue / dual-issue uop buffer between decode and scoreboard.
// Ports: enq_valid/enq_uop0/enq_uop1/enq_ready in; issue0/1 slots, accept0/1, count out.
module issue_queue
    import cu_issue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PAYLOAD_W  = 64,
    parameter bit ENQ_CHECK  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [1:0]                 enq_valid,
    input  uop_t                       enq_uop0,
    input  uop_t                       enq_uop1,
    output logic                       enq_ready,
    output logic                       issue0_valid,
    output uop_t                       issue0_uop,
    output logic                       issue1_valid,
    output uop_t                       issue1_uop,
    input  logic                       stall0,
    input  logic                       stall1,
    input  logic                       exec_ready,
    output logic                       accept0,
    output logic                       accept1,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // The uop layout is fixed by the package; a mismatched override is a build error.
    if (PAYLOAD_W != cu_issue_pkg::PAYLOAD_W) begin : g_bad_payload
        $error("issue_queue: PAYLOAD_W must match cu_issue_pkg::PAYLOAD_W");
    end

    uop_t            mem [DEPTH];
    logic [IW-1:0]   head;
    logic [IW-1:0]   tail;
    logic [IW-1:0]   head1;
    logic [IW-1:0]   tail1;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic            enq_ready_q;
    logic            enq_fire;
    logic [1:0]      n_enq;
    logic [1:0]      n_deq;

    // DEPTH is a power of two, so plain IW-bit adds wrap the ring.
    assign head1 = head + 1'b1;
    assign tail1 = tail + 1'b1;

    assign issue0_uop   = mem[head];
    assign issue1_uop   = mem[head1];
    assign issue0_valid = (count_q != '0);
    assign issue1_valid = (count_q > CW'(1));
    assign enq_ready    = enq_ready_q;
    assign count        = count_q;

    issue_pair_check u_pair (
        .issue0_valid (issue0_valid),
        .issue1_valid (issue1_valid),
        .unit0        (issue0_uop.unit),
        .unit1        (issue1_uop.unit),
        .ctrl0        (issue0_uop.is_ctrl),
        .ctrl1        (issue1_uop.is_ctrl),
        .stall0       (stall0),
        .stall1       (stall1),
        .exec_ready   (exec_ready),
        .flush        (flush),
        .accept0      (accept0),
        .accept1      (accept1)
    );

    assign enq_fire = enq_ready_q & ~flush;
    assign n_enq    = enq_fire ? ({1'b0, enq_valid[0]} + {1'b0, enq_valid[1]})
                               : 2'd0;
    assign n_deq    = {1'b0, accept0} + {1'b0, accept1};

    assign count_next = count_q + CW'(n_enq) - CW'(n_deq);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            enq_ready_q <= 1'b1;
        end else begin
            head        <= head + IW'(n_deq);
            tail        <= tail + IW'(n_enq);
            count_q     <= count_next;
            // Registered so a full queue never sees same-cycle dequeue space.
            enq_ready_q <= (count_next <= CW'(DEPTH - 2));
        end
    end

    // Storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (rst_n && enq_fire) begin
            case (enq_valid)
                2'b11: begin
                    mem[tail]  <= enq_uop0;
                    mem[tail1] <= enq_uop1;
                end
                2'b01:   mem[tail] <= enq_uop0;
                2'b10:   mem[tail] <= enq_uop1;
                default: ;
            endcase
        end
    end

    // Decode must hold its uops while the queue is not ready.
    if (ENQ_CHECK) begin : g_enq_check
        always_ff @(posedge clk) begin
            if (rst_n && !flush && (enq_valid != 2'b00)) begin
                assert (enq_ready_q)
                else $error("issue_queue: enqueue while enq_ready=0");
            end
        end
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- In-order, dual-ported decoded-uop buffer between decode and the dual-issue scoreboard of the compute unit.
- Accepts up to two decoded uops per cycle from decode.
- Presents the two oldest entries as issue slot 0 and slot 1, combines scoreboard stalls with structural pairing rules into accept0/accept1, and retires accepted entries strictly in program order.

Parameters:
- DEPTH, 8, number of uop entries; power of two, >= 4.
- PAYLOAD_W, 64, opaque per-uop payload bits (opcode, imm, pc), passed through unmodified.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  global flush (branch redirect); discards all entries.
- enq_valid  in  2  bit0 = enq_uop0 valid, bit1 = enq_uop1 valid; uop0 is older.
- enq_uop0  in  UOP_W  decoded uop, uop_t from the package.
- enq_uop1  in  UOP_W  decoded uop.
- enq_ready  out  1  1 when free entries >= 2.
- issue0_valid  out  1  queue holds >= 1 entry.
- issue0_uop  out  UOP_W  entry at head.
- issue1_valid  out  1  queue holds >= 2 entries.
- issue1_uop  out  UOP_W  entry at head+1.
- stall0  in  1  scoreboard hazard stall, slot 0.
- stall1  in  1  scoreboard hazard stall, slot 1.
- exec_ready  in  1  back end can take instructions this cycle.
- accept0  out  1  slot 0 enters the pipe this cycle.
- accept1  out  1  slot 1 enters the pipe this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0 at posedge) and flush: head=tail=0, count=0. The following then hold:
  - issue0_valid=issue1_valid=0
  - accept0=accept1=0
  - enq_ready=1
- flush wins over any same-cycle enqueue or dequeue: that cycle's enqueues are dropped and accepts are forced to 0.
- Storage: circular array of DEPTH uop_t. head/tail are $clog2(DEPTH)-bit indices that wrap modulo DEPTH; count is tracked separately, so full and empty are unambiguous.
- Slot outputs read combinationally from registered storage at head and head+1 (mod DEPTH).
- Enqueue happens only when enq_ready=1.
  - 2'b11 writes uop0 at tail and uop1 at tail+1; tail += 2.
  - 2'b01 writes uop0 at tail; tail += 1.
  - 2'b10 writes uop1 at tail; tail += 1.
  - enq_valid while enq_ready=0 is dropped; decode must hold it. Assert in simulation.
- Uop fields (package): rs1_v, rs2_v, rd_v; rs1_cls, rs2_cls, rd_cls (2b: 00 scalar, 01 fp, 1x vector); rs1, rs2, rd (5b); rs1_fwd, rs2_fwd; unit (2b: 00 ALU, 01 LSU, 10 FPU, 11 VEC); is_ctrl; payload.
- pair_ok = issue1_uop.unit != issue0_uop.unit AND !issue0_uop.is_ctrl AND !issue1_uop.is_ctrl.
- accept0 = issue0_valid & !stall0 & exec_ready & !flush.
- accept1 = accept0 & issue1_valid & !stall1 & pair_ok.
  - Slot 1 never issues without slot 0 (in order).
- Dequeue: head += accept0 + accept1. Enqueue and dequeue in the same cycle are both applied: count_next = count + n_enq − n_deq.
- Full queue with simultaneous dequeue: enq_ready is still 0 that cycle. It is computed from registered count only; no same-cycle bypass.
- Empty queue: an enqueued uop first becomes visible on issue0 the next cycle. Minimum decode-to-accept latency is 1 cycle.
- All outputs except the issue/accept combinational terms are registered.

Decomposition:
- Package cu_issue_pkg holds:
  - uop_t packed struct and UOP_W
  - reg-class constants CLS_S/CLS_F/CLS_V
  - unit constants UNIT_ALU/LSU/FPU/VEC
- The scoreboard imports the same class constants.
- One natural sub-module: issue_pair_check, the combinational pair_ok and accept logic, which can be tested standalone.

Test Plan:
1. Reset, then enq 2'b11 ALU + LSU, no stalls, exec_ready=1 → next cycle issue0/issue1 valid, accept0=accept1=1; the cycle after, count=0.
2. Fill with 8 uops (4 × 2'b11) and hold stall0=1 → count=8, enq_ready=0; a 5th enq is dropped and count stays 8.
3. Head ALU, head+1 ALU (same unit) → accept0=1, accept1=0; next cycle the second ALU is issue0 and accept0=1.
4. stall0=0, stall1=1 with pairable uops → accept0=1, accept1=0, head advances by 1. Then stall0=1, stall1=0 → both accepts 0.
5. Wrap-around: 12 single enqueues interleaved with accepts (DEPTH=8) → issue order matches enqueue order, payloads 0..11 with no corruption across index 7→0.
6. flush with count=5 and enq_valid=2'b11 in the same cycle → next cycle count=0, issue0_valid=0, accepts were 0 during the flush cycle.
